// File: rtl/pattern_lut_pkg.sv
// Shared types and helpers for the pattern lookup table: FSM state encoding
// and the init-pattern function used by both the sweep logic and models.
package pattern_lut_pkg;

  // Two-phase lifecycle: the sweep owns the array in ST_INIT, users in ST_RUN.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Wide enough for DATA_W + ADDR_W of any sensible configuration, so the
  // product idx * step never loses bits before the final truncation.
  localparam int unsigned CALC_W = 64;

  // Pattern value for entry idx: (base + idx * step) mod 2^width.
  // Wrap-around is intended, so the raw sum is simply masked.
  function automatic logic [CALC_W-1:0] init_val(
    input logic [CALC_W-1:0] base,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] idx,
    input int unsigned       width
  );
    logic [CALC_W-1:0] raw;
    logic [CALC_W-1:0] mask;
    raw  = base + idx * step;
    mask = (width >= CALC_W) ? '1 : ((CALC_W'(1) << width) - CALC_W'(1));
    return raw & mask;
  endfunction

endpackage

// File: rtl/lut_mem_array.sv
// Plain DATA_W x DEPTH storage: one synchronous write port and one
// combinational read port. A read and write to the same entry in the same
// cycle therefore returns the old contents (read-before-write).
module lut_mem_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store one entry per enabled cycle.
  // NOTE: the storage array is deliberately not reset; the init sweep defines
  // every entry before it can be read, so a reset would only add fan-out.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement or process order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read; the caller registers the result.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pattern_lut.sv
// Runtime-writable lookup table pre-loaded with an arithmetic pattern.
// After reset (or a soft_init pulse) a sweep writes one entry per cycle;
// once finished the table serves registered reads and accepts writes.
module pattern_lut
  import pattern_lut_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int          INIT_BASE = 0,
  parameter int          INIT_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_init,
  output logic              init_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable (e.g. DEPTH = 2^ADDR_W).
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // FSM and sweep index
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Storage port signals
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] sweep_data;

  // Request qualification
  logic rd_in_range;
  logic wr_in_range;
  logic rd_ok;

  // Registered read response
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);

  // Pattern value for the entry the sweep is writing this cycle.
  assign sweep_data = DATA_W'(init_val(CALC_W'(INIT_BASE), CALC_W'(INIT_STEP),
                                       CALC_W'(idx_q), DATA_W));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register and sweep index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: sweep DEPTH entries, then run until soft_init.
  // NOTE: every combinational output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        if (soft_init) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_init) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: the table is usable exactly while in ST_RUN.
  always_comb begin
    init_done = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------------
  // Write muxing: the sweep owns the array in ST_INIT; user writes are
  // accepted only in ST_RUN, in range, and not alongside soft_init.
  // ---------------------------------------------------------------------

  // Select between sweep and user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr[IDX_W-1:0];
    mem_wdata = wr_data;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = sweep_data;
    end else if (wr_en && wr_in_range && !soft_init) begin
      mem_we = 1'b1;
    end
  end

  lut_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_addr[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // ---------------------------------------------------------------------
  // Read path: one response per request; rejected requests return zero.
  // ---------------------------------------------------------------------

  // Build the response for this cycle's request.
  always_comb begin
    rd_ok      = rd_en && (state_q == ST_RUN) && rd_in_range;
    rd_valid_d = rd_en;
    rd_err_d   = rd_en && !rd_ok;
    rd_data_d  = rd_ok ? mem_rdata : '0;
  end

  // Response register; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;

  // ---------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------

  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n)
    idx_q <= IDX_LAST);

  a_run_idx_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_RUN) |-> (idx_q == '0));

  a_err_qualified : assert property (@(posedge clk) disable iff (!rst_n)
    rd_err |-> rd_valid);

  a_err_data_zero : assert property (@(posedge clk) disable iff (!rst_n)
    rd_err |-> (rd_data == '0));

endmodule

// File: tb/tb_pattern_lut.sv
// Self-checking bench for pattern_lut. The main instance (defaults) is
// driven by directed steps plus random traffic and compared with a
// behavioural table model; two extra instances cover other geometries.
module tb_pattern_lut;

  localparam int M_DEPTH = 8;
  localparam int M_W     = 4;
  localparam int M_BASE  = 0;
  localparam int M_STEP  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance
  logic       soft_init, rd_en, wr_en;
  logic [7:0] rd_addr, wr_addr;
  logic [3:0] wr_data;
  logic       init_done, rd_valid, rd_err;
  logic [3:0] rd_data;

  // Instance B: DEPTH 16, base 1, step 2, 4-bit (wraps)
  logic       rd_en_b;
  logic [7:0] rd_addr_b;
  logic       init_done_b, rd_valid_b, rd_err_b;
  logic [3:0] rd_data_b;

  // Instance C: DEPTH 256, 8-bit data, every address valid
  logic       rd_en_c;
  logic [7:0] rd_addr_c;
  logic       init_done_c, rd_valid_c, rd_err_c;
  logic [7:0] rd_data_c;

  pattern_lut #(.DATA_W(4), .DEPTH(8), .ADDR_W(8), .INIT_BASE(0), .INIT_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .soft_init(soft_init), .init_done(init_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  pattern_lut #(.DATA_W(4), .DEPTH(16), .ADDR_W(8), .INIT_BASE(1), .INIT_STEP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_init(1'b0), .init_done(init_done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .rd_err(rd_err_b), .wr_en(1'b0), .wr_addr(8'd0), .wr_data(4'd0)
  );

  pattern_lut #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .INIT_BASE(0), .INIT_STEP(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .soft_init(1'b0), .init_done(init_done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_valid(rd_valid_c), .rd_data(rd_data_c),
    .rd_err(rd_err_c), .wr_en(1'b0), .wr_addr(8'd0), .wr_data(8'd0)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the main instance: table contents plus the number
  // of edges still needed before the table becomes usable again.
  int model [M_DEPTH];
  int init_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void refill();
    for (int i = 0; i < M_DEPTH; i++) model[i] = (M_BASE + i * M_STEP) % (1 << M_W);
  endfunction

  // One clock of main-instance traffic, checked against the model.
  task automatic cycle(input bit re, input int ra, input bit we, input int wa,
                       input int wd, input bit si);
    bit busy, exp_err;
    int exp_data;
    rd_en = re; rd_addr = 8'(ra);
    wr_en = we; wr_addr = 8'(wa); wr_data = 4'(wd);
    soft_init = si;
    busy     = (init_left > 0);
    exp_err  = busy || (ra >= M_DEPTH);
    exp_data = exp_err ? 0 : model[ra];
    if (we && !busy && !si && wa < M_DEPTH) model[wa] = wd;
    if (si) begin
      init_left = M_DEPTH;
      refill();
    end else if (init_left > 0) begin
      init_left--;
    end
    tick();
    check("rd_valid", 32'(rd_valid), 32'(re));
    if (re) begin
      check($sformatf("rd_err@%0d", ra), 32'(rd_err), 32'(exp_err));
      check($sformatf("rd_data@%0d", ra), 32'(rd_data), 32'(exp_data));
    end
    check("init_done", 32'(init_done), 32'(init_left == 0));
    rd_en = 1'b0; wr_en = 1'b0; soft_init = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  // Assert reset, check outputs clear at once, release after one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; soft_init = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    tick();
    rst_n = 1'b1;
    init_left = M_DEPTH;
    refill();
  endtask

  initial begin
    rst_n = 1'b1;
    soft_init = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd_en_b = 1'b0; rd_addr_b = '0;
    rd_en_c = 1'b0; rd_addr_c = '0;
    #2;
    do_reset();

    // Read during the sweep is rejected; init_done rises on the 8th edge.
    cycle(1'b1, 3, 1'b0, 0, 0, 1'b0);
    check("early_rd_err", 32'(rd_err), 32'd1);
    idle(6);
    check("init_done_edge7", 32'(init_done), 32'd0);
    idle(1);
    check("init_done_edge8", 32'(init_done), 32'd1);

    // Back-to-back readout of the reset pattern.
    for (int i = 0; i < M_DEPTH; i++) begin
      cycle(1'b1, i, 1'b0, 0, 0, 1'b0);
      check($sformatf("pattern[%0d]", i), 32'(rd_data), 32'(2 * i));
    end

    // Write then read, same-cycle read-before-write, dropped OOB write.
    cycle(1'b0, 0, 1'b1, 3, 9, 1'b0);
    cycle(1'b1, 3, 1'b0, 0, 0, 1'b0);
    check("wr3_rd3", 32'(rd_data), 32'd9);
    cycle(1'b1, 5, 1'b1, 5, 1, 1'b0);
    check("rbw_old5", 32'(rd_data), 32'd10);
    cycle(1'b1, 5, 1'b0, 0, 0, 1'b0);
    check("rbw_new5", 32'(rd_data), 32'd1);
    cycle(1'b0, 0, 1'b1, 8, 7, 1'b0);
    cycle(1'b1, 8, 1'b0, 0, 0, 1'b0);
    check("oob_rd_err", 32'(rd_err), 32'd1);

    // Soft re-init restores the pattern after 8 edges.
    cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
    check("soft_init_done_low", 32'(init_done), 32'd0);
    idle(M_DEPTH);
    cycle(1'b1, 3, 1'b0, 0, 0, 1'b0);
    check("restored3", 32'(rd_data), 32'd6);
    cycle(1'b1, 5, 1'b0, 0, 0, 1'b0);
    check("restored5", 32'(rd_data), 32'd10);

    // Random mixed traffic, including occasional soft_init.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end
    idle(M_DEPTH);

    // Reset at sweep index 4 with a response in flight.
    cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
    idle(3);
    cycle(1'b1, 2, 1'b0, 0, 0, 1'b0);
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    do_reset();
    idle(M_DEPTH - 1);
    check("rst_sweep_edge7", 32'(init_done), 32'd0);
    idle(1);
    for (int i = 0; i < M_DEPTH; i++) cycle(1'b1, i, 1'b0, 0, 0, 1'b0);

    // Wide/deep instances: let the 256-entry sweep finish.
    repeat (260) tick();
    check("b_init_done", 32'(init_done_b), 32'd1);
    check("c_init_done", 32'(init_done_c), 32'd1);

    for (int i = 0; i <= 16; i++) begin
      rd_en_b = 1'b1; rd_addr_b = 8'(i);
      tick();
      check($sformatf("b_valid[%0d]", i), 32'(rd_valid_b), 32'd1);
      check($sformatf("b_err[%0d]", i), 32'(rd_err_b), 32'(i >= 16));
      check($sformatf("b_data[%0d]", i), 32'(rd_data_b),
            (i >= 16) ? 32'd0 : 32'((1 + 2 * i) % 16));
    end
    rd_en_b = 1'b0;
    tick();
    check("b_valid_drop", 32'(rd_valid_b), 32'd0);

    for (int i = 0; i < 256; i++) begin
      rd_en_c = 1'b1; rd_addr_c = 8'(i);
      tick();
      check($sformatf("c_err[%0d]", i), 32'(rd_err_c), 32'd0);
      check($sformatf("c_data[%0d]", i), 32'(rd_data_c), 32'((2 * i) % 256));
    end
    rd_en_c = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
